hilo_unit: RTL
==============

# hilo_unit

Architectural HI/LO register pair sitting directly downstream of the integer ALU. It captures the ALU's 64-bit product for MUL and accumulates it for MADD/MADDU. It also services MTHI/MTLO and runs a multi-cycle restoring divider for DIV/DIVU, with a ready/busy/done handshake back to the issue stage. HI/LO are exposed continuously for MFHI/MFLO.

## Interface
- WIDTH, 32, datapath width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  command present this cycle.
- op  in  3  command:
  - 000 NOP; 001 MUL_WR; 010 MADD_ACC; 011 MTHI; 100 MTLO; 101 DIV; 110 DIVU.
  - 111 is reserved and treated as NOP.
- alu_hi, alu_lo  in  WIDTH each  ALU 64-bit product, signed or unsigned as the ALU computed it.
- rs_val  in  WIDTH  MTHI/MTLO source; dividend.
- rt_val  in  WIDTH  divisor.
- ready  out  1  command accepted this cycle when op_valid and ready are both high; equals !busy.
- busy  out  1  divide in progress.
- done  out  1  one-cycle pulse when the accepted command's HI/LO result is visible.
- div_by_zero  out  1  one-cycle pulse, coincident with done, for a divide with rt_val==0.
- hi, lo  out  WIDTH each  current architectural registers.

## Operation
- **Reset values:** hi=0, lo=0, busy=0, done=0, div_by_zero=0. The FSM is in IDLE.
- **States:** IDLE, DIV, FIX.
- **Accept:** a command is accepted when op_valid && ready. Commands presented while busy are ignored, and the issuer must hold them.
- **MUL_WR:** {hi,lo} <= {alu_hi,alu_lo}.
- **MADD_ACC:** {hi,lo} <= {hi,lo} + {alu_hi,alu_lo}, as a 64-bit modulo-2^64 add with no flags.
- **MTHI:** hi <= rs_val, lo unchanged.
- **MTLO:** lo <= rs_val, hi unchanged.
- **NOP/111:** no state change and no done pulse.
- **DIV/DIVU accept in IDLE:**
  - If rt_val==0: stay in IDLE, leave hi/lo unchanged, pulse done and div_by_zero.
  - Otherwise: latch |dividend| and |divisor| (raw operands for DIVU) plus sign flags, then go to DIV with iteration counter = 0.
- **DIV state:** one restoring step per cycle, producing one quotient bit, MSB first. After WIDTH steps, go to FIX.
- **FIX state:** apply signs, then lo <= quotient and hi <= remainder. Assert done, clear busy, return to IDLE.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- **HI/LO during a divide:** hi/lo keep their pre-divide values until the FIX edge.
- **Reset mid-divide:** the divide is abandoned and all reset values are restored immediately.

## Timing
- **Single-cycle ops (MUL_WR, MADD_ACC, MTHI, MTLO):** accepted at edge E. hi/lo update at edge E and done is high in the cycle after E.
  - Back-to-back acceptance every cycle is allowed.
  - MADD_ACC sees the hi/lo written by the previous cycle's op.
- **Divide:** accepted at edge E0.
  - busy rises at E0.
  - Iteration edges are E1..E32 (WIDTH edges).
  - FIX at E33 writes hi/lo, drops busy and raises done.
  - ready is high in the done cycle, so a new op may be accepted at E34.
  - Latency is WIDTH+1 edges from accept to result.
- **Divide by zero:** done and div_by_zero are high in the cycle after the accept edge; busy never rises.
- **Outputs:** hi and lo are driven directly from the registers, with no combinational path from the inputs. done and div_by_zero are registered.

## Configuration
- **HILO_DIV_EN defined:** divider, DIV/FIX states and div_by_zero logic are compiled in, as described above.
- **HILO_DIV_EN undefined:**
  - DIV and DIVU behave as single-cycle no-ops: hi/lo unchanged, done pulses the cycle after accept.
  - busy is tied 0 and ready is tied 1.
  - div_by_zero is tied 0.

## Structure
- **Package hilo_pkg:**
  - op encoding enum hilo_op_t;
  - FSM state enum hilo_state_t;
  - WIDTH default constant;
  - signed-division overflow constants.
- **Sub-module hilo_divider:** unsigned restoring divider core with start, a step counter, and quotient/remainder outputs. It is instantiated only under HILO_DIV_EN.
- **Top level:** sign handling, accumulate adder, handshake.

## Test plan
- **MUL then MADD:** MUL_WR with alu_hi=0x1, alu_lo=0xFFFFFFFF, then MADD_ACC with alu_hi=0, alu_lo=0x1. Required: hi=0x2, lo=0x0, and done high for 2 consecutive cycles.
- **MTHI/MTLO isolation:** MTHI with rs=0xDEADBEEF, then MTLO with rs=0x12345678. Required: hi=0xDEADBEEF, lo=0x12345678, each write touching only its own register.
- **Signed divide:** DIV with rs=-7 (0xFFFFFFF9), rt=2. Required: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done exactly 33 edges after accept, busy high for the intervening cycles, and ready low throughout. A MTLO presented mid-divide must be ignored.
- **Unsigned divide:** DIVU with rs=0xFFFFFFF9, rt=2. Required: lo=0x7FFFFFFC, hi=0x1.
- **Divide by zero:** any divide with rt=0 from hi=0xA, lo=0xB. Required: done and div_by_zero pulse one cycle after accept, busy stays 0, hi=0xA and lo=0xB.
- **Reset mid-divide:** assert rst_n low at iteration 10. Required: hi=lo=0, busy=0 and done=0 immediately (asynchronously). A subsequent MUL_WR must work normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register unit.
// The divider is compiled in only when HILO_DIV_EN is defined.
package hilo_pkg;

   localparam int unsigned HILO_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_NOP      = 3'd0,
      OP_MUL_WR   = 3'd1,
      OP_MADD_ACC = 3'd2,
      OP_MTHI     = 3'd3,
      OP_MTLO     = 3'd4,
      OP_DIV      = 3'd5,
      OP_DIVU     = 3'd6,
      OP_RSVD     = 3'd7
   } hilo_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2
   } hilo_state_t;

   // Signed-division overflow corner: INT_MIN / -1 yields INT_MIN, remainder 0
   localparam logic [HILO_WIDTH-1:0] HILO_INT_MIN = {1'b1, {(HILO_WIDTH-1){1'b0}}};
   localparam logic [HILO_WIDTH-1:0] HILO_NEG_ONE = '1;

endpackage

// File: rtl/hilo_divider.sv
// Unsigned restoring divider core: one quotient bit per step, MSB first.
// Instantiated by hilo_unit only when HILO_DIV_EN is defined.
module hilo_divider
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = HILO_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quo,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_last_c
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;

   // Quotient register doubles as the dividend shifter
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_rem <= '0;
         r_quo <= i_dividend;
         r_dvs <= i_divisor;
         r_cnt <= '0;
      end else if (i_step) begin
         if (w_trial[WIDTH]) begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
         end else begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
         end
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_quo    = r_quo;
   assign o_rem    = r_rem;
   assign o_last_c = i_step && (r_cnt == CW'(WIDTH-1));

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO pair: MUL write, multiply-accumulate, MTHI/MTLO and
// an optional multi-cycle signed/unsigned divider (define HILO_DIV_EN).
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = HILO_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] alu_hi,
   input  logic [WIDTH-1:0] alu_lo,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned DW = 2 * WIDTH;

   hilo_op_t         w_op;
   logic             w_is_div;
   logic [DW-1:0]    w_acc;
   logic [WIDTH-1:0] w_sc_hi;
   logic [WIDTH-1:0] w_sc_lo;
   logic             w_sc_done;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic             w_done_nxt;

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;

   assign w_op     = hilo_op_t'(op);
   assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
   assign w_acc    = {r_hi, r_lo} + {alu_hi, alu_lo};

   // Single-cycle command decode, shared by both builds
   always_comb begin
      w_sc_hi   = r_hi;
      w_sc_lo   = r_lo;
      w_sc_done = 1'b0;
      case (w_op)
         OP_MUL_WR: begin
            w_sc_hi   = alu_hi;
            w_sc_lo   = alu_lo;
            w_sc_done = 1'b1;
         end
         OP_MADD_ACC: begin
            {w_sc_hi, w_sc_lo} = w_acc;
            w_sc_done          = 1'b1;
         end
         OP_MTHI: begin
            w_sc_hi   = rs_val;
            w_sc_done = 1'b1;
         end
         OP_MTLO: begin
            w_sc_lo   = rs_val;
            w_sc_done = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef HILO_DIV_EN
   hilo_state_t      r_state;
   hilo_state_t      w_state_nxt;
   logic             r_busy;
   logic             r_dbz;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             w_busy_nxt;
   logic             w_dbz_nxt;
   logic             w_start;
   logic             w_step;
   logic             w_accept;
   logic             w_signed;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_abs;
   logic [WIDTH-1:0] w_b_abs;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;
   logic             w_last_c;

   assign w_accept = op_valid && !r_busy;
   assign w_signed = (w_op == OP_DIV);
   assign w_a_neg  = w_signed && rs_val[WIDTH-1];
   assign w_b_neg  = w_signed && rt_val[WIDTH-1];
   assign w_a_abs  = w_a_neg ? (~rs_val + WIDTH'(1)) : rs_val;
   assign w_b_abs  = w_b_neg ? (~rt_val + WIDTH'(1)) : rt_val;

   // Quotient truncates toward zero; remainder follows the dividend's sign
   assign w_q_fix  = r_neg_q ? (~w_quo + WIDTH'(1)) : w_quo;
   assign w_r_fix  = r_neg_r ? (~w_rem + WIDTH'(1)) : w_rem;

   hilo_divider #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_start),
      .i_step     (w_step),
      .i_dividend (w_a_abs),
      .i_divisor  (w_b_abs),
      .o_quo      (w_quo),
      .o_rem      (w_rem),
      .o_last_c   (w_last_c)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_done_nxt  = 1'b0;
      w_dbz_nxt   = 1'b0;
      w_busy_nxt  = r_busy;
      w_start     = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_hi_nxt   = w_sc_hi;
               w_lo_nxt   = w_sc_lo;
               w_done_nxt = w_sc_done;
               if (w_is_div) begin
                  if (rt_val == '0) begin
                     w_done_nxt = 1'b1;
                     w_dbz_nxt  = 1'b1;
                  end else begin
                     w_start     = 1'b1;
                     w_busy_nxt  = 1'b1;
                     w_state_nxt = ST_DIV;
                  end
               end
            end
         end
         ST_DIV: begin
            w_step = 1'b1;
            if (w_last_c) w_state_nxt = ST_FIX;
         end
         ST_FIX: begin
            w_hi_nxt    = w_r_fix;
            w_lo_nxt    = w_q_fix;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_dbz   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_dbz  <= w_dbz_nxt;
         if (w_start) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
         end
      end
   end

   assign ready       = !r_busy;
   assign busy        = r_busy;
   assign div_by_zero = r_dbz;
`else
   logic w_unused;

   // Divides complete immediately as no-ops
   always_comb begin
      w_hi_nxt   = r_hi;
      w_lo_nxt   = r_lo;
      w_done_nxt = 1'b0;
      if (op_valid) begin
         w_hi_nxt   = w_sc_hi;
         w_lo_nxt   = w_sc_lo;
         w_done_nxt = w_sc_done || w_is_div;
      end
   end

   assign w_unused    = ^rt_val;
   assign ready       = 1'b1;
   assign busy        = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_hi   <= w_hi_nxt;
         r_lo   <= w_lo_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign done = r_done;

endmodule
